count_display: RTL and testbench

COUNT_DISPLAY -- requirements
Module: count_display

---
 rtl/count_display.sv | 162 ++++++++++++++++
 tb/tb_count_display.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/count_display.sv
// Three-digit multiplexed 7-segment display of an 8-bit count, using a sequential double-dabble BCD converter.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros in the hundreds and tens digits.
module count_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] count,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t        state;
    logic [7:0]    shadow;
    logic [7:0]    bin_sr;
    logic [8:0]    bcd_sr;
    logic [2:0]    step;
    logic [3:0]    dig_h;
    logic [3:0]    dig_t;
    logic [3:0]    dig_o;
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    scan_idx;

    logic [8:0]    bcd_adj;
    logic [9:0]    next_bcd;
    logic [7:0]    next_bin;
    logic          latch_digits;
    logic          refresh_wrap;
    logic [3:0]    nxt_h;
    logic [3:0]    nxt_t;
    logic [3:0]    nxt_o;
    logic [1:0]    nxt_scan;
    logic [3:0]    disp_code;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign dp = 1'b1;

    // The hundreds nibble is at most 1 before the final shift, so one bit of it
    // suffices in the shift register; the full 2-bit hundreds appears only in next_bcd.
    // seg/an are registered from next-state digits and scan index so a freshly
    // latched result is visible in the same cycle busy drops.
    always_comb begin
        bcd_adj = bcd_sr;
        if (bcd_sr[3:0] >= 4'd5) bcd_adj[3:0] = bcd_sr[3:0] + 4'd3;
        if (bcd_sr[7:4] >= 4'd5) bcd_adj[7:4] = bcd_sr[7:4] + 4'd3;
        next_bcd = {bcd_adj, bin_sr[7]};
        next_bin = {bin_sr[6:0], 1'b0};

        latch_digits = (state == CONVERT) && (step == 3'd7);
        nxt_h = latch_digits ? {2'b00, next_bcd[9:8]} : dig_h;
        nxt_t = latch_digits ? next_bcd[7:4] : dig_t;
        nxt_o = latch_digits ? next_bcd[3:0] : dig_o;

        refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));
        nxt_scan = scan_idx;
        if (refresh_wrap) nxt_scan = (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;

        case (nxt_scan)
            2'd0: begin
                disp_code = nxt_o;
                an_next   = 4'b1110;
            end
            2'd1: begin
                disp_code = nxt_t;
`ifdef LEADING_ZERO_BLANK_EN
                if (nxt_h == 4'd0 && nxt_t == 4'd0) disp_code = 4'hF;
`endif
                an_next   = 4'b1101;
            end
            2'd2: begin
                disp_code = nxt_h;
`ifdef LEADING_ZERO_BLANK_EN
                if (nxt_h == 4'd0) disp_code = 4'hF;
`endif
                an_next   = 4'b1011;
            end
            default: begin
                disp_code = 4'hF;
                an_next   = 4'b1111;
            end
        endcase
        seg_next = seg_decode(disp_code);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            shadow      <= 8'd0;
            bin_sr      <= 8'd0;
            bcd_sr      <= 9'd0;
            step        <= 3'd0;
            dig_h       <= 4'd0;
            dig_t       <= 4'd0;
            dig_o       <= 4'd0;
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
            an          <= 4'b1110;
            seg         <= 7'b1000000;
        end else begin
            refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RW'(1);
            scan_idx    <= nxt_scan;
            an          <= an_next;
            seg         <= seg_next;
            dig_h       <= nxt_h;
            dig_t       <= nxt_t;
            dig_o       <= nxt_o;
            case (state)
                IDLE: begin
                    if (count != shadow) begin
                        shadow <= count;
                        bin_sr <= count;
                        bcd_sr <= 9'd0;
                        step   <= 3'd0;
                        state  <= CONVERT;
                        busy   <= 1'b1;
                    end
                end
                CONVERT: begin
                    bin_sr <= next_bin;
                    bcd_sr <= next_bcd[8:0];
                    step   <= step + 3'd1;
                    if (step == 3'd7) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display at REFRESH_DIV=4; a cycle counter models the scan
// position and hand-set digits model the expected display.
module tb_count_display;

    localparam int DIV = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] count = 8'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_h = 0;
    int   exp_t = 0;
    int   exp_o = 0;
    logic exp_busy = 1'b0;
    logic [6:0] seg_tbl [0:9];

    count_display #(.REFRESH_DIV(DIV)) dut (
        .clock(clock),
        .reset(reset),
        .count(count),
        .an(an),
        .seg(seg),
        .dp(dp),
        .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] expected_seg(input int idx);
        logic [6:0] s;
        case (idx)
            0: s = seg_tbl[exp_o];
            1: begin
                s = seg_tbl[exp_t];
`ifdef LEADING_ZERO_BLANK_EN
                if (exp_h == 0 && exp_t == 0) s = 7'b1111111;
`endif
            end
            default: begin
                s = seg_tbl[exp_h];
`ifdef LEADING_ZERO_BLANK_EN
                if (exp_h == 0) s = 7'b1111111;
`endif
            end
        endcase
        return s;
    endfunction

    task automatic tick();
        @(posedge clock);
        if (reset) cyc = 0;
        else cyc++;
        #1;
    endtask

    task automatic check_output(input string tag);
        int         idx;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        idx     = (cyc / DIV) % 3;
        exp_an  = (idx == 0) ? 4'b1110 : (idx == 1) ? 4'b1101 : 4'b1011;
        exp_seg = expected_seg(idx);
        checks++;
        assert (an === exp_an) else begin
            errors++;
            $error("[TB] FAIL %s an: got %b expected %b (cycle %0d)", tag, an, exp_an, cyc);
        end
        checks++;
        assert (seg === exp_seg) else begin
            errors++;
            $error("[TB] FAIL %s seg: got %b expected %b (cycle %0d)", tag, seg, exp_seg, cyc);
        end
        checks++;
        assert (busy === exp_busy) else begin
            errors++;
            $error("[TB] FAIL %s busy: got %b expected %b (cycle %0d)", tag, busy, exp_busy, cyc);
        end
        checks++;
        assert (dp === 1'b1) else begin
            errors++;
            $error("[TB] FAIL %s dp: got %b expected 1", tag, dp);
        end
    endtask

    task automatic run(input int n, input logic b, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            exp_busy = b;
            check_output(tag);
        end
    endtask

    task automatic set_digits(input int h, input int t, input int o);
        exp_h = h;
        exp_t = t;
        exp_o = o;
    endtask

    initial begin
        seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001;
        seg_tbl[2] = 7'b0100100; seg_tbl[3] = 7'b0110000;
        seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
        seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000;
        seg_tbl[8] = 7'b0000000; seg_tbl[9] = 7'b0010000;

        $display("[TB] reset and idle scan");
        reset = 1'b1;
        count = 8'd0;
        set_digits(0, 0, 0);
        tick();
        tick();
        exp_busy = 1'b0;
        check_output("reset");
        checks++;
        assert (seg === 7'b1000000) else begin
            errors++;
            $error("[TB] FAIL reset_seg: got %b expected 1000000", seg);
        end
        reset = 1'b0;
        run(13, 1'b0, "idle_scan");

        $display("[TB] count 0 -> 255");
        count = 8'd255;
        run(8, 1'b1, "conv255_busy");
        set_digits(2, 5, 5);
        run(1, 1'b0, "conv255_done");
        run(12, 1'b0, "show255");

        $display("[TB] count 255 -> 7");
        count = 8'd7;
        run(8, 1'b1, "conv7_busy");
        set_digits(0, 0, 7);
        run(13, 1'b0, "show7");

        $display("[TB] count 100 then 42 mid-conversion");
        count = 8'd100;
        run(3, 1'b1, "conv100_busy");
        count = 8'd42;
        run(5, 1'b1, "conv100_busy_late");
        set_digits(1, 0, 0);
        run(1, 1'b0, "show100_idle");
        run(8, 1'b1, "conv42_busy");
        set_digits(0, 4, 2);
        run(1, 1'b0, "conv42_done");
        run(12, 1'b0, "show42");

        $display("[TB] reset during conversion to 200");
        count = 8'd200;
        run(4, 1'b1, "conv200_busy");
        reset = 1'b1;
        tick();
        set_digits(0, 0, 0);
        exp_busy = 1'b0;
        check_output("reset_mid_conv");
        reset = 1'b0;
        run(8, 1'b1, "reconv200_busy");
        set_digits(2, 0, 0);
        run(1, 1'b0, "reconv200_done");
        run(12, 1'b0, "show200");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
